lfsr_decrypt: RTL and testbench

Receive-side counterpart of the `lfsr` keystream generator. Takes a ciphertext byte stream produced by XOR with the LFSR pseudo-random byte and regenerates the same keystream from a loaded seed. It checks and strips a fixed preamble, then emits decrypted message bytes on a valid/ready output. It sits between the ciphertext source (memory reader or serial receiver) and the plaintext consumer.

---
 rtl/lfsr_decrypt_if.sv | 26 ++
 rtl/lfsr_decrypt.sv | 109 ++++++++++
 tb/tb_lfsr_decrypt.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_decrypt_if.sv
// Ciphertext-in / plaintext-out handshake bundle for lfsr_decrypt.
// The master (source/consumer side) drives the control and data inputs; the slave is the decryptor.
interface lfsr_decrypt_if;
  logic [31:0] seed;
  logic [7:0]  msg_len;
  logic        seed_ld;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output seed, msg_len, seed_ld, in_byte, in_valid, out_ready,
    input  in_ready, out_byte, out_valid, busy, done, err
  );

  modport slave (
    input  seed, msg_len, seed_ld, in_byte, in_valid, out_ready,
    output in_ready, out_byte, out_valid, busy, done, err
  );
endinterface

// File: rtl/lfsr_decrypt.sv
// LFSR keystream decryptor: checks and strips a plaintext preamble, then emits message bytes
// through a one-entry valid/ready output register.
module lfsr_decrypt #(
  parameter int unsigned PREAMBLE_LEN  = 7,
  parameter logic [7:0]  PREAMBLE_CHAR = 8'h5F,
  parameter logic [31:0] TAP_MASK      = 32'h4000_1064
) (
  input logic           clk,
  input logic           rst_n,
  lfsr_decrypt_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PRE, DATA, DONE, ERR} state_t;

  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);

  state_t      state_q, state_d;
  logic [31:0] lfsr_q;
  logic [7:0]  cnt_q, len_q, out_byte_q;
  logic        out_valid_q;
  logic        in_ready_c, busy_c, done_c, err_c;
  logic [7:0]  key, plain;
  logic        accept, drain, match, last_pre, last_data;

  assign key       = lfsr_q[7:0] ^ lfsr_q[15:8] ^ lfsr_q[23:16] ^ {1'b1, lfsr_q[30:24]};
  assign plain     = bus.in_byte ^ key;
  assign match     = (plain == PREAMBLE_CHAR);
  assign last_pre  = (cnt_q == PRE_LAST);
  // DATA is only entered with len_q != 0, so this never underflows while it matters.
  assign last_data = (cnt_q == len_q - 8'd1);
  assign accept    = bus.in_valid & in_ready_c;
  assign drain     = out_valid_q & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
    state_d = state_q;
    if (bus.seed_ld) begin
      state_d = (bus.seed == 32'd0) ? ERR : PRE;
    end else if (accept) begin
      case (state_q)
        PRE: begin
          if (!match)        state_d = ERR;
          else if (last_pre) state_d = (len_q == 8'd0) ? DONE : DATA;
        end
        DATA: if (last_data) state_d = DONE;
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready_c = 1'b0;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    err_c      = 1'b0;
    case (state_q)
      PRE: begin
        in_ready_c = !bus.seed_ld;
        busy_c     = 1'b1;
      end
      DATA: begin
        in_ready_c = !bus.seed_ld & (!out_valid_q | bus.out_ready);
        busy_c     = 1'b1;
      end
      DONE:    done_c = !out_valid_q;
      ERR:     err_c  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q      <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      out_byte_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (bus.seed_ld) begin
      // A new message drops any pending output byte.
      lfsr_q      <= bus.seed;
      cnt_q       <= '0;
      len_q       <= bus.msg_len;
      out_valid_q <= 1'b0;
    end else begin
      if (drain) out_valid_q <= 1'b0;
      if (accept) begin
        // The key of this byte was taken from the pre-step state above.
        lfsr_q <= {lfsr_q[30:0], ^(lfsr_q & TAP_MASK)};
        cnt_q  <= ((state_q == PRE) ? last_pre : last_data) ? 8'd0 : cnt_q + 8'd1;
        if (state_q == DATA) begin
          out_byte_q  <= plain;
          out_valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_byte  = out_byte_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.err       = err_c;
endmodule

// File: tb/tb_lfsr_decrypt.sv
// Self-checking bench for lfsr_decrypt: fixed vectors, hand-written corner sequences and
// randomized messages checked against a keystream model.
module tb_lfsr_decrypt;
  localparam int          PL    = 2;
  localparam logic [7:0]  PCHAR = 8'h5F;
  localparam logic [31:0] TAPS  = 32'h4000_1064;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [7:0] in_byte;
    logic       exp_valid;
    logic [7:0] exp_byte;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lfsr_decrypt_if bus();

  lfsr_decrypt #(.PREAMBLE_LEN(PL), .PREAMBLE_CHAR(PCHAR), .TAP_MASK(TAPS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Model: generator state after n steps; feedback is the odd parity of the tapped bits.
  function automatic logic [31:0] state_after(input logic [31:0] seed, input int n);
    logic [31:0] s = seed;
    for (int i = 0; i < n; i++) s = (s << 1) | 32'($countones(s & TAPS) % 2);
    return s;
  endfunction

  function automatic bq_t keystream(input logic [31:0] seed, input int n);
    bq_t ks;
    logic [31:0] s;
    for (int i = 0; i < n; i++) begin
      s = state_after(seed, i);
      ks.push_back(8'(s) ^ 8'(s >> 8) ^ 8'(s >> 16) ^ (8'((s >> 24) & 32'h7F) | 8'h80));
    end
    return ks;
  endfunction

  task automatic make_msg(input logic [31:0] seed, input int len, output bq_t ct, output bq_t pts);
    bq_t ks;
    logic [7:0] pt;
    ks = keystream(seed, PL + len);
    ct = {};
    pts = {};
    for (int i = 0; i < PL + len; i++) begin
      pt = (i < PL) ? PCHAR : 8'($urandom);
      ct.push_back(pt ^ ks[i]);
      if (i >= PL) pts.push_back(pt);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input logic [31:0] seed, input logic [7:0] len);
    bus.seed     = seed;
    bus.msg_len  = len;
    bus.seed_ld  = 1'b1;
    bus.in_valid = 1'b0;
    cycle();
    bus.seed_ld = 1'b0;
  endtask

  // Streams ct[idx0..] with optional random stalls on both sides, scoring every output byte.
  task automatic stream(input bq_t ct, input int idx0, input bq_t exp_in, input bit rnd);
    bq_t exp = exp_in;
    int idx = idx0;
    int cyc = 0;
    int budget = 20 * (ct.size() + 2) + 50;
    while (cyc < budget && !(idx == ct.size() && exp.size() == 0)) begin
      bus.out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.in_valid  = (idx < ct.size()) && (!rnd || $urandom_range(0, 3) != 0);
      bus.in_byte   = (idx < ct.size()) ? ct[idx] : 8'h00;
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (exp.size() == 0) check("extra_out", 32'd1, 32'd0);
        else                 check("data_byte", bus.out_byte, exp.pop_front());
      end
      if (bus.in_valid && bus.in_ready) idx++;
      cycle();
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("msg_budget", cyc < budget, 1);
    check("msg_done", bus.done, 1);
    check("msg_busy", bus.busy, 0);
    check("msg_err", bus.err, 0);
  endtask

  task automatic run_msg(input logic [31:0] seed, input int len, input bit rnd);
    bq_t ct, pts;
    make_msg(seed, len, ct, pts);
    load(seed, 8'(len));
    stream(ct, 0, pts, rnd);
  endtask

  // Loads, passes the preamble and buffers the first data byte with out_ready held low.
  task automatic prefix_to_data(input logic [31:0] seed, input int len, output bq_t ct, output bq_t pts);
    make_msg(seed, len, ct, pts);
    load(seed, 8'(len));
    bus.out_ready = 1'b0;
    for (int i = 0; i <= PL; i++) begin
      bus.in_valid = 1'b1;
      bus.in_byte  = ct[i];
      cycle();
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    vec_t vecs[3];
    bq_t  ct, pts;
    logic [31:0] s2;

    vecs[0] = '{8'hDE, 1'b0, 8'h00};
    vecs[1] = '{8'hDD, 1'b0, 8'h00};
    vecs[2] = '{8'hC5, 1'b1, 8'h41};

    bus.seed = '0; bus.msg_len = '0; bus.seed_ld = 1'b0;
    bus.in_byte = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_byte", bus.out_byte, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    rst_n = 1'b1;
    cycle();

    // Basic decode from fixed vectors.
    load(32'h1, 8'd1);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_byte  = vecs[i].in_byte;
      #1 check("basic_in_ready", bus.in_ready, 1);
      cycle();
      check("basic_valid", bus.out_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) check("basic_byte", bus.out_byte, vecs[i].exp_byte);
    end
    bus.in_valid = 1'b0;
    check("basic_done_pending", bus.done, 0);
    cycle();
    check("basic_drained", bus.out_valid, 0);
    check("basic_done", bus.done, 1);

    // Preamble mismatch, then recovery by a new load.
    load(32'h1, 8'd1);
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'hDF;
    cycle();
    bus.in_valid = 1'b0;
    check("mis_err", bus.err, 1);
    check("mis_in_ready", bus.in_ready, 0);
    check("mis_out_valid", bus.out_valid, 0);
    cycle();
    check("mis_err_sticky", bus.err, 1);
    load(32'h1, 8'd1);
    check("mis_err_cleared", bus.err, 0);
    check("mis_busy", bus.busy, 1);

    // Zero seed.
    load(32'h0, 8'd3);
    check("zero_err", bus.err, 1);
    check("zero_busy", bus.busy, 0);
    check("zero_in_ready", bus.in_ready, 0);

    // Back-pressure: one buffered byte, input stalled, generator frozen.
    prefix_to_data(32'hA5A5_1234, 4, ct, pts);
    bus.in_valid = 1'b1;
    bus.in_byte  = ct[PL + 1];
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_out_byte", bus.out_byte, pts[0]);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_state", dut.lfsr_q, state_after(32'hA5A5_1234, PL + 1));
      cycle();
    end
    stream(ct, PL + 1, pts, 1'b0);

    // seed_ld collides with a byte while an output is pending.
    prefix_to_data(32'h0BAD_F00D, 3, ct, pts);
    s2 = 32'h1357_9BDF;
    bus.seed     = s2;
    bus.msg_len  = 8'd2;
    bus.seed_ld  = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_byte  = ct[PL + 1];
    #1 check("col_in_ready", bus.in_ready, 0);
    cycle();
    bus.seed_ld  = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("col_out_valid", bus.out_valid, 0);
    check("col_busy", bus.busy, 1);
    check("col_in_ready_pre", bus.in_ready, 1);
    check("col_state", dut.lfsr_q, s2);
    make_msg(s2, 2, ct, pts);
    stream(ct, 0, pts, 1'b0);

    // Asynchronous reset while DATA holds a pending byte.
    prefix_to_data(32'hCAFE_0001, 3, ct, pts);
    check("pre_rst_out_valid", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_out_byte", bus.out_byte, 0);
    check("arst_in_ready", bus.in_ready, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    check("arst_err", bus.err, 0);
    check("arst_state", dut.lfsr_q, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_byte  = ct[PL + 1];
    #1 check("idle_in_ready", bus.in_ready, 0);
    cycle();
    bus.in_valid = 1'b0;
    check("idle_busy", bus.busy, 0);
    check("idle_out_valid", bus.out_valid, 0);

    // Boundaries: empty message and the longest message.
    run_msg(32'h8000_0000, 0, 1'b0);
    run_msg(32'h7654_3210, 255, 1'b0);

    // Randomized messages with random stalls on both sides.
    for (int m = 0; m < 12; m++) begin
      logic [31:0] sd;
      sd = $urandom;
      if (sd == 32'd0) sd = 32'd1;
      run_msg(sd, $urandom_range(0, 12), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end
endmodule
